// File: rtl/radio_decimation2.sv
// -----------------------------------------------------------------------------
// radio_decimation2
//   Per-lane 2:1 decimator for the radio receive path. Paired I/Q AXI-stream
//   samples (IN_W-bit signed) are low-pass filtered with a [1 2 1]/4 kernel
//   spanning the previous output's odd sample (history), the even sample and
//   the odd sample of the current pair. Each output is rounded half-up and
//   saturated to OUT_W bits. I and Q move in lockstep and share one phase FSM.
//   The output is produced one cycle after the sample that completes a pair.
//
// Ports
//   clk_500m, reset_n            clock, asynchronous active-low reset
//   s_axis_inputI_* / inputQ_*   upstream I/Q streams (tvalid/tready/tdata/tlast)
//   m_axis_outputI_* / outputQ_* downstream I/Q streams (tready/tvalid/tdata/tlast)
//   lane_err                     sticky flag: I/Q tlast disagreed on an accepted
//                                sample; cleared only by reset
// -----------------------------------------------------------------------------
module radio_decimation2 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk_500m,
  input  logic             reset_n,

  input  logic             s_axis_inputI_tvalid,
  output logic             s_axis_inputI_tready,
  input  logic [IN_W-1:0]  s_axis_inputI_tdata,
  input  logic             s_axis_inputI_tlast,

  input  logic             s_axis_inputQ_tvalid,
  output logic             s_axis_inputQ_tready,
  input  logic [IN_W-1:0]  s_axis_inputQ_tdata,
  input  logic             s_axis_inputQ_tlast,

  input  logic             m_axis_outputI_tready,
  output logic             m_axis_outputI_tvalid,
  output logic [OUT_W-1:0] m_axis_outputI_tdata,
  output logic             m_axis_outputI_tlast,

  input  logic             m_axis_outputQ_tready,
  output logic             m_axis_outputQ_tvalid,
  output logic [OUT_W-1:0] m_axis_outputQ_tdata,
  output logic             m_axis_outputQ_tlast,

  output logic             lane_err
);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_e;

  // Accumulator carries IN_W+2 bits for h+2e+o plus one more so the rounding
  // offset cannot overflow at full-scale positive input.
  localparam int ACC_W = IN_W + 3;
  localparam int SHIFT = IN_W - OUT_W + 2;
  localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);

  function automatic logic signed [ACC_W-1:0] sext(input logic [IN_W-1:0] x);
    return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
  endfunction

  // (h + 2e + o + RND) >>> SHIFT, then clamp. The shifted result is OUT_W+1
  // bits wide, so overflow shows up as the top two bits disagreeing.
  function automatic logic [OUT_W-1:0] filt(input logic [IN_W-1:0] h,
                                            input logic [IN_W-1:0] e,
                                            input logic [IN_W-1:0] o);
    logic signed [ACC_W-1:0] acc;
    logic [OUT_W:0]          y;
    acc = sext(h) + (sext(e) <<< 1) + sext(o) + RND;
    y   = acc[ACC_W-1:SHIFT];
    if (y[OUT_W] != y[OUT_W-1])
      return y[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    return y[OUT_W-1:0];
  endfunction

  phase_e            phase_q;
  logic [IN_W-1:0]   e_ich_q, e_qch_q;
  logic [IN_W-1:0]   hist_ich_q, hist_qch_q;
  logic              e_last_q;
  logic              m_valid_q, m_last_q, lane_err_q;
  logic [OUT_W-1:0]  m_data_ich_q, m_data_qch_q;

  logic              s_ready, accept, xfer, frame_end;
  logic              produce_d, last_d;
  logic [IN_W-1:0]   e_ich_d, e_qch_d, o_ich_d, o_qch_d;
  logic [OUT_W-1:0]  y_ich_d, y_qch_d;

  assign s_ready   = !m_valid_q | (m_axis_outputI_tready & m_axis_outputQ_tready);
  assign accept    = s_axis_inputI_tvalid & s_axis_inputQ_tvalid & s_ready;
  assign xfer      = m_valid_q & m_axis_outputI_tready & m_axis_outputQ_tready;
  assign frame_end = s_axis_inputI_tlast | s_axis_inputQ_tlast;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    produce_d = 1'b0;
    last_d    = 1'b0;
    e_ich_d   = e_ich_q;
    e_qch_d   = e_qch_q;
    o_ich_d   = s_axis_inputI_tdata;
    o_qch_d   = s_axis_inputQ_tdata;
    if (accept) begin
      if (phase_q == ODD) begin
        produce_d = 1'b1;
        last_d    = frame_end | e_last_q;
      end else if (frame_end) begin
        // Odd-length frame flush: the lone even sample stands in for o too.
        produce_d = 1'b1;
        last_d    = 1'b1;
        e_ich_d   = s_axis_inputI_tdata;
        e_qch_d   = s_axis_inputQ_tdata;
      end
    end
    y_ich_d = filt(hist_ich_q, e_ich_d, o_ich_d);
    y_qch_d = filt(hist_qch_q, e_qch_d, o_qch_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_500m or negedge reset_n) begin
    if (!reset_n) begin
      phase_q      <= EVEN;
      e_ich_q      <= '0;
      e_qch_q      <= '0;
      e_last_q     <= 1'b0;
      hist_ich_q   <= '0;
      hist_qch_q   <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_ich_q <= '0;
      m_data_qch_q <= '0;
      lane_err_q   <= 1'b0;
    end else begin
      if (xfer) m_valid_q <= 1'b0;
      if (accept) begin
        lane_err_q <= lane_err_q | (s_axis_inputI_tlast ^ s_axis_inputQ_tlast);
        case (phase_q)
          EVEN: begin
            e_ich_q  <= s_axis_inputI_tdata;
            e_qch_q  <= s_axis_inputQ_tdata;
            e_last_q <= frame_end;
            if (!frame_end) phase_q <= ODD;
          end
          default: phase_q <= EVEN;
        endcase
        if (produce_d) begin
          m_valid_q    <= 1'b1;
          m_last_q     <= last_d;
          m_data_ich_q <= y_ich_d;
          m_data_qch_q <= y_qch_d;
          // Frames are filtered independently: no history across a frame end.
          hist_ich_q   <= frame_end ? '0 : o_ich_d;
          hist_qch_q   <= frame_end ? '0 : o_qch_d;
        end
      end
    end
  end

  assign s_axis_inputI_tready  = s_ready;
  assign s_axis_inputQ_tready  = s_ready;
  assign m_axis_outputI_tvalid = m_valid_q;
  assign m_axis_outputQ_tvalid = m_valid_q;
  assign m_axis_outputI_tdata  = m_data_ich_q;
  assign m_axis_outputQ_tdata  = m_data_qch_q;
  assign m_axis_outputI_tlast  = m_last_q;
  assign m_axis_outputQ_tlast  = m_last_q;
  assign lane_err              = lane_err_q;

endmodule
